sha3_work_dispatcher: RTL and testbench
=======================================

Name: sha3_work_dispatcher

Overview:
Upstream feeder for the scanner instantiator. Accepts one job (block template, threshold, inclusive nonce range) and splits the range into scan_count-sized chunks. For each chunk it patches the start nonce into the template and strobes the scanner. It stops on the first in-range hit or when the range is exhausted, then posts one result record to the host-side control logic.

Parameters:
PROPER, 1, template layout selector; INPUT_ELEMENTS = PROPER ? 20 : 24 (localparam)
NONCE_INDEX, INPUT_ELEMENTS-1, template word overwritten with the chunk start nonce

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
job_valid  in  1  job offered
job_ready  out  1  high only in IDLE; job accepted when job_valid & job_ready
job_template  in  32 x INPUT_ELEMENTS  block template
job_threshold  in  64  difficulty threshold
job_first_nonce  in  32  first nonce, inclusive
job_last_nonce  in  32  last nonce, inclusive
scan_start  out  1  one-cycle start strobe to scanner
scan_blobby  out  32 x INPUT_ELEMENTS  latched template with nonce patched in
scan_threshold  out  64  latched threshold, held stable for the whole job
scan_idle  in  1  scanner idle
scan_found  in  1  scanner result valid; held until the next scanner start
scan_nonce  in  32  scanner result nonce
scan_hash  in  64 x 25  scanner result hash
scan_count  in  32  scanner chunk size, constant
res_valid  out  1  result record valid
res_ready  in  1  result consumed when res_valid & res_ready
res_found  out  1  1 = hit, 0 = range exhausted
res_nonce  out  32  hit nonce, or 0 when exhausted
res_hash  out  64 x 25  hit hash, or 0 when exhausted
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: job_ready=1, scan_start=0, res_valid=0, res_found=0, res_nonce=0, res_hash all 0, busy=0, scan_blobby and scan_threshold 0. State goes to IDLE. A reset mid-job abandons the job; the scanner is not stopped and is later resynchronised by ISSUE waiting for scan_idle.
- IDLE: on job accept, latch template, threshold and range, and set cur=first.
  - If first>last: go to REPORT with res_found=0. The scanner is never started.
  - Otherwise go to ISSUE.
- ISSUE: write cur into scan_blobby[NONCE_INDEX]. Wait for scan_idle=1, then assert scan_start for exactly one cycle. scan_blobby is stable from at least one cycle before the strobe. Go to ACK.
- ACK: wait for scan_idle=0, then go to RUN.
- RUN: wait for scan_idle=1 (rising back), then evaluate the chunk:
  - scan_found=1 and scan_nonce in [first,last]: latch nonce and hash, res_found=1, go to REPORT.
  - scan_found=1 with nonce > last (overshoot in final chunk): treat as exhausted.
  - Otherwise compute next=cur+scan_count in 33 bits. If carry, or next>last, or scan_count==0: res_found=0, go to REPORT. Else cur=next, go to ISSUE.
- REPORT: res_valid held high until res_ready. Result fields are stable while valid. On handshake go to IDLE. job_ready rises the following cycle, with no combinational path from res_ready to job_ready.
- Minimum loop overhead per chunk: 3 cycles (ISSUE, ACK, RUN evaluation) beyond the scanner's own busy time.
- last=0xFFFFFFFF: wrap is detected via the carry bit, so no infinite loop.

Optional Feature:
SHA3_DISPATCH_ABORT_EN:
- Defined: adds input abort (1 bit). Abort is ignored in IDLE and REPORT.
  - In ISSUE: return to IDLE immediately; no strobe is issued.
  - In ACK or RUN: enter DRAIN, wait for scan_idle=1, then go to IDLE.
  - No result is posted for an aborted job.
- Undefined: no port, no DRAIN state.

Decomposition:
- Package sha3_dispatch_pkg: state enum (IDLE, ISSUE, ACK, RUN, REPORT, DRAIN), function input_elements(proper), result record struct (found, nonce, hash).
- Sub-module sha3_nonce_range_stepper: holds cur, first and last. Outputs next and exhausted (33-bit compare). Has load and step strobes.

Test Plan:
- Scanner model with scan_count=256, no hit; job range 0..1023 -> 4 scanner starts with blobby nonce 0,256,512,768; then res_valid with res_found=0.
- Same job, model hits at nonce 600 in chunk 3 -> exactly 3 starts; res_found=1, res_nonce=600, res_hash equal to the model's hash.
- Range 0xFFFFFF00..0xFFFFFFFF, scan_count=256 -> exactly one start; exhausted reported, no wrap to nonce 0.
- first=10, last=5 -> no scan_start ever asserted; res_found=0 within 3 cycles of accept.
- Hold res_ready=0 for 20 cycles -> res_valid and result fields stable; job_ready=0 throughout. rst pulse mid-RUN -> all outputs at reset values the next cycle.
- With SHA3_DISPATCH_ABORT_EN: abort during RUN -> no further starts; busy falls only after scan_idle=1; no res_valid.

Source files
------------

// File: rtl/sha3_dispatch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sha3_dispatch_pkg                                                        |
// | Shared FSM state codes, result record and template sizing helper for     |
// | the SHA-3 work dispatcher.                                               |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package sha3_dispatch_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ISSUE  = 3'd1;
  localparam state_t ST_ACK    = 3'd2;
  localparam state_t ST_RUN    = 3'd3;
  localparam state_t ST_REPORT = 3'd4;
`ifdef SHA3_DISPATCH_ABORT_EN
  localparam state_t ST_DRAIN  = 3'd5;
`endif

  localparam int HASH_W = 64 * 25;

  typedef struct packed {
    logic              found;
    logic [31:0]       nonce;
    logic [HASH_W-1:0] hash;
  } result_t;

  function automatic int input_elements(input int proper);
    return (proper != 0) ? 20 : 24;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha3_nonce_range_stepper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sha3_nonce_range_stepper                                                 |
// | Holds the current chunk nonce and the inclusive job range; produces the  |
// | next chunk start and a 33-bit exhaustion flag.                           |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module sha3_nonce_range_stepper (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] load_first,
  input  logic [31:0] load_last,
  input  logic [31:0] scan_count,
  output logic [31:0] first,
  output logic [31:0] last,
  output logic [31:0] next,
  output logic        exhausted
);

  logic [31:0] cur_q, cur_d;
  logic [31:0] first_q, first_d;
  logic [31:0] last_q, last_d;
  logic [32:0] sum;

  // The carry bit is what stops a range ending at 0xFFFFFFFF from wrapping.
  assign sum       = {1'b0, cur_q} + {1'b0, scan_count};
  assign next      = sum[31:0];
  assign exhausted = sum[32] | (sum[31:0] > last_q) | (scan_count == 32'd0);
  assign first     = first_q;
  assign last      = last_q;

  always_comb begin
    cur_d   = cur_q;
    first_d = first_q;
    last_d  = last_q;
    if (load) begin
      cur_d   = load_first;
      first_d = load_first;
      last_d  = load_last;
    end else if (step) begin
      cur_d = sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q   <= 32'd0;
      first_q <= 32'd0;
      last_q  <= 32'd0;
    end else begin
      cur_q   <= cur_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha3_work_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sha3_work_dispatcher                                                     |
// | Splits one nonce-range job into scanner-sized chunks, patches each chunk |
// | start into the template, strobes the scanner and posts one result.       |
// | Optional macro SHA3_DISPATCH_ABORT_EN adds an abort input and DRAIN.     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module sha3_work_dispatcher
  import sha3_dispatch_pkg::*;
#(
  parameter int PROPER      = 1,
  parameter int NONCE_INDEX = input_elements(PROPER) - 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  job_valid,
  output logic                                  job_ready,
  input  logic [32*input_elements(PROPER)-1:0]  job_template,
  input  logic [63:0]                           job_threshold,
  input  logic [31:0]                           job_first_nonce,
  input  logic [31:0]                           job_last_nonce,
  output logic                                  scan_start,
  output logic [32*input_elements(PROPER)-1:0]  scan_blobby,
  output logic [63:0]                           scan_threshold,
  input  logic                                  scan_idle,
  input  logic                                  scan_found,
  input  logic [31:0]                           scan_nonce,
  input  logic [HASH_W-1:0]                     scan_hash,
  input  logic [31:0]                           scan_count,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic                                  res_found,
  output logic [31:0]                           res_nonce,
  output logic [HASH_W-1:0]                     res_hash,
`ifdef SHA3_DISPATCH_ABORT_EN
  input  logic                                  abort,
`endif
  output logic                                  busy
);

  localparam int INPUT_ELEMENTS = input_elements(PROPER);
  localparam int TMPL_W         = 32 * INPUT_ELEMENTS;

  state_t              state_q, state_d;
  logic [TMPL_W-1:0]   blobby_q, blobby_d;
  logic [63:0]         thr_q, thr_d;
  result_t             res_q, res_d;
  logic                start_q, start_d;
  logic                load, step;
  logic [31:0]         rng_first, rng_last, rng_next;
  logic                rng_exhausted;
  logic                abort_req;

`ifdef SHA3_DISPATCH_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  sha3_nonce_range_stepper u_stepper (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .load_first (job_first_nonce),
    .load_last  (job_last_nonce),
    .scan_count (scan_count),
    .first      (rng_first),
    .last       (rng_last),
    .next       (rng_next),
    .exhausted  (rng_exhausted)
  );

  // The nonce word is patched on entry to ISSUE so the template is settled
  // a full cycle before the registered strobe fires.
  always_comb begin
    state_d  = state_q;
    blobby_d = blobby_q;
    thr_d    = thr_q;
    res_d    = res_q;
    start_d  = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          load     = 1'b1;
          blobby_d = job_template;
          blobby_d[NONCE_INDEX*32 +: 32] = job_first_nonce;
          thr_d    = job_threshold;
          if (job_first_nonce > job_last_nonce) begin
            res_d   = '0;
            state_d = ST_REPORT;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (abort_req) begin
          state_d = ST_IDLE;
        end else if (scan_idle) begin
          start_d = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (abort_req) begin
`ifdef SHA3_DISPATCH_ABORT_EN
          state_d = ST_DRAIN;
`endif
        end else if (!scan_idle) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_req) begin
`ifdef SHA3_DISPATCH_ABORT_EN
          state_d = ST_DRAIN;
`endif
        end else if (scan_idle) begin
          if (scan_found && (scan_nonce >= rng_first) && (scan_nonce <= rng_last)) begin
            res_d.found = 1'b1;
            res_d.nonce = scan_nonce;
            res_d.hash  = scan_hash;
            state_d     = ST_REPORT;
          end else if (rng_exhausted) begin
            res_d   = '0;
            state_d = ST_REPORT;
          end else begin
            step     = 1'b1;
            blobby_d[NONCE_INDEX*32 +: 32] = rng_next;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_REPORT: begin
        if (res_ready) state_d = ST_IDLE;
      end
`ifdef SHA3_DISPATCH_ABORT_EN
      ST_DRAIN: begin
        if (scan_idle) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      blobby_q <= '0;
      thr_q    <= 64'd0;
      res_q    <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      blobby_q <= blobby_d;
      thr_q    <= thr_d;
      res_q    <= res_d;
      start_q  <= start_d;
    end
  end

  assign job_ready      = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign res_valid      = (state_q == ST_REPORT);
  assign scan_start     = start_q;
  assign scan_blobby    = blobby_q;
  assign scan_threshold = thr_q;
  assign res_found      = res_q.found;
  assign res_nonce      = res_q.nonce;
  assign res_hash       = res_q.hash;

endmodule
`default_nettype wire

// File: tb/tb_sha3_work_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sha3_work_dispatcher                                                  |
// | Directed bench with a behavioural scanner model for the work dispatcher. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_sha3_work_dispatcher;

  localparam int NE = 20;
  localparam int NI = NE - 1;
  localparam int TW = NE * 32;
  localparam int HW = 1600;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [TW-1:0] job_template;
  logic [63:0]   job_threshold = 64'hDEAD_BEEF_0123_4567;
  logic [31:0]   job_first_nonce = 32'd0;
  logic [31:0]   job_last_nonce = 32'd0;
  logic          scan_start;
  logic [TW-1:0] scan_blobby;
  logic [63:0]   scan_threshold;
  logic          scan_idle;
  logic          scan_found = 1'b0;
  logic [31:0]   scan_nonce = 32'd0;
  logic [HW-1:0] scan_hash = '0;
  logic [31:0]   scan_count = 32'd256;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic          res_found;
  logic [31:0]   res_nonce;
  logic [HW-1:0] res_hash;
  logic          busy;
  logic          abort = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sha3_work_dispatcher dut (
    .clk             (clk),
    .rst             (rst),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_template    (job_template),
    .job_threshold   (job_threshold),
    .job_first_nonce (job_first_nonce),
    .job_last_nonce  (job_last_nonce),
    .scan_start      (scan_start),
    .scan_blobby     (scan_blobby),
    .scan_threshold  (scan_threshold),
    .scan_idle       (scan_idle),
    .scan_found      (scan_found),
    .scan_nonce      (scan_nonce),
    .scan_hash       (scan_hash),
    .scan_count      (scan_count),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_found       (res_found),
    .res_nonce       (res_nonce),
    .res_hash        (res_hash),
`ifdef SHA3_DISPATCH_ABORT_EN
    .abort           (abort),
`endif
    .busy            (busy)
  );

  function automatic logic [HW-1:0] hash_of(input logic [31:0] n);
    return {25{n ^ 32'hA5A5_0000, ~n}};
  endfunction

  // Scanner model: busy for m_busy cycles per start, hit reported at the end.
  logic        m_hit_en = 1'b0;
  logic [31:0] m_hit = 32'd0;
  logic [31:0] m_base = 32'd0;
  int          m_busy = 6;
  int          m_cnt = 0;
  int          n_starts = 0;
  logic [31:0] start_log[$];

  assign scan_idle = (m_cnt == 0);

  always @(posedge clk) begin
    if (scan_start && m_cnt == 0) begin
      m_base     <= scan_blobby[NI*32 +: 32];
      start_log.push_back(scan_blobby[NI*32 +: 32]);
      n_starts   <= n_starts + 1;
      m_cnt      <= m_busy;
      scan_found <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && m_hit_en && m_hit >= m_base &&
          ({1'b0, m_hit} - {1'b0, m_base}) < {1'b0, scan_count}) begin
        scan_found <= 1'b1;
        scan_nonce <= m_hit;
        scan_hash  <= hash_of(m_hit);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept_job(input string tag, input logic [31:0] f, input logic [31:0] l);
    int cyc;
    cyc = 0;
    job_first_nonce = f;
    job_last_nonce  = l;
    job_valid       = 1'b1;
    while (!job_ready && cyc < 1000) begin
      tick();
      cyc++;
    end
    chk({tag, " job_ready"}, 64'(job_ready), 64'd1);
    tick();
    job_valid = 1'b0;
  endtask

  task automatic do_job(input string tag, input logic [31:0] f, input logic [31:0] l,
                        input bit exp_found, input logic [31:0] exp_nonce,
                        input int exp_starts, input int max_lat, input int hold);
    int s0;
    int cyc;
    logic [HW-1:0] exp_hash;
    exp_hash = exp_found ? hash_of(exp_nonce) : '0;
    s0 = n_starts;
    start_log.delete();
    accept_job(tag, f, l);
    cyc = 1;
    while (!res_valid && cyc < 5000) begin
      tick();
      cyc++;
    end
    chk({tag, " res_valid"}, 64'(res_valid), 64'd1);
    if (max_lat > 0) chk({tag, " latency_ok"}, 64'(cyc <= max_lat), 64'd1);
    for (int i = 0; i < hold; i++) begin
      chk({tag, " res_found"}, 64'(res_found), 64'(exp_found));
      chk({tag, " res_nonce"}, 64'(res_nonce), 64'(exp_nonce));
      chk({tag, " res_hash_ok"}, 64'(res_hash == exp_hash), 64'd1);
      chk({tag, " job_ready_low"}, 64'(job_ready), 64'd0);
      chk({tag, " res_valid_held"}, 64'(res_valid), 64'd1);
      tick();
    end
    chk({tag, " starts"}, 64'(n_starts - s0), 64'(exp_starts));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, " res_valid_drop"}, 64'(res_valid), 64'd0);
    chk({tag, " job_ready_back"}, 64'(job_ready), 64'd1);
  endtask

  initial begin
    int cyc;
    int s0;
    logic [31:0] exp_starts[4];
    exp_starts = '{32'd0, 32'd256, 32'd512, 32'd768};
    for (int i = 0; i < NE; i++) job_template[i*32 +: 32] = 32'h1000_0000 + 32'(i);

    tick(); tick(); tick();
    chk("rst job_ready", 64'(job_ready), 64'd1);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst res_valid", 64'(res_valid), 64'd0);
    chk("rst scan_start", 64'(scan_start), 64'd0);
    chk("rst blobby_zero", 64'(scan_blobby == '0), 64'd1);
    chk("rst threshold", scan_threshold, 64'd0);
    rst = 1'b0;
    tick();

    // Four full chunks, no hit.
    do_job("nohit", 32'd0, 32'd1023, 1'b0, 32'd0, 4, 0, 1);
    chk("nohit log_size", 64'(start_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < start_log.size(); i++)
      chk($sformatf("nohit start%0d", i), 64'(start_log[i]), 64'(exp_starts[i]));
    chk("tmpl word0", 64'(scan_blobby[31:0]), 64'h1000_0000);
    chk("tmpl word18", 64'(scan_blobby[18*32 +: 32]), 64'h1000_0012);
    chk("threshold", scan_threshold, 64'hDEAD_BEEF_0123_4567);

    // Hit in the third chunk, result held for 20 cycles.
    m_hit_en = 1'b1;
    m_hit    = 32'd600;
    do_job("hit600", 32'd0, 32'd1023, 1'b1, 32'd600, 3, 0, 20);

    // Top-of-range chunk must not wrap to nonce 0.
    m_hit_en = 1'b0;
    do_job("toprange", 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b0, 32'd0, 1, 0, 1);
    if (start_log.size() > 0) chk("toprange start", 64'(start_log[0]), 64'hFFFF_FF00);
    else chk("toprange start_seen", 64'd0, 64'd1);

    // Empty range: report without starting the scanner.
    do_job("empty", 32'd10, 32'd5, 1'b0, 32'd0, 0, 3, 1);

    // Hit beyond last in the final chunk counts as exhausted.
    m_hit_en = 1'b1;
    m_hit    = 32'd700;
    do_job("overshoot", 32'd0, 32'd599, 1'b0, 32'd0, 3, 0, 1);

    // Reset while the scanner is busy.
    m_hit_en = 1'b0;
    accept_job("rstrun", 32'd0, 32'd1023);
    cyc = 0;
    while (scan_idle && cyc < 100) begin tick(); cyc++; end
    chk("rstrun scanner_busy", 64'(scan_idle), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rstrun job_ready", 64'(job_ready), 64'd1);
    chk("rstrun busy", 64'(busy), 64'd0);
    chk("rstrun scan_start", 64'(scan_start), 64'd0);
    chk("rstrun res_valid", 64'(res_valid), 64'd0);
    chk("rstrun res_found", 64'(res_found), 64'd0);
    chk("rstrun res_nonce", 64'(res_nonce), 64'd0);
    chk("rstrun res_hash_zero", 64'(res_hash == '0), 64'd1);
    chk("rstrun blobby_zero", 64'(scan_blobby == '0), 64'd1);
    chk("rstrun threshold", scan_threshold, 64'd0);
    rst = 1'b0;
    m_hit_en = 1'b1;
    m_hit    = 32'd5;
    do_job("resync", 32'd0, 32'd255, 1'b1, 32'd5, 1, 0, 1);

`ifdef SHA3_DISPATCH_ABORT_EN
    m_hit_en = 1'b0;
    accept_job("abort", 32'd0, 32'd1023);
    cyc = 0;
    while (scan_idle && cyc < 100) begin tick(); cyc++; end
    tick();
    s0 = n_starts;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cyc = 0;
    while (!scan_idle && cyc < 100) begin
      chk("abort busy_held", 64'(busy), 64'd1);
      chk("abort no_res", 64'(res_valid), 64'd0);
      tick();
      cyc++;
    end
    chk("abort scanner_idle", 64'(scan_idle), 64'd1);
    tick();
    chk("abort busy_low", 64'(busy), 64'd0);
    chk("abort job_ready", 64'(job_ready), 64'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("abort no_more_starts", 64'(n_starts - s0), 64'd0);
    chk("abort res_valid", 64'(res_valid), 64'd0);
`else
    s0 = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
